// File: rtl/pixel_pack_sender_if.sv
// Handshake bundle of the pixel packer: the 16-bit pixel stream coming in and
// the 33-bit epack word stream going out to the pixel data collector.
//   pixel_in / pixel_valid / pixel_ready : pixel stream, transfer = valid & ready
//   epack / epack_valid / epack_ready    : packed word stream, transfer = valid & ready
//   frame_done                           : one-cycle pulse after the last word of a frame
// master = the packer, slave = the environment around it.
interface pixel_pack_sender_if;
   logic [15:0] pixel_in;
   logic        pixel_valid;
   logic        pixel_ready;
   logic [32:0] epack;
   logic        epack_valid;
   logic        epack_ready;
   logic        frame_done;

   modport master (
      input  pixel_in, pixel_valid, epack_ready,
      output pixel_ready, epack, epack_valid, frame_done
   );

   modport slave (
      output pixel_in, pixel_valid, epack_ready,
      input  pixel_ready, epack, epack_valid, frame_done
   );
endinterface

// File: rtl/pixel_pack_sender.sv
// Transmit end of the epack link: packs pairs of 16-bit pixels into 33-bit
// words ([15:0] first pixel, [31:16] second pixel, [32] start of frame).
// An odd frame length pads the last word with zeros in the upper half.
// Ports:
//   clk   : system clock, rising edge
//   rstn  : asynchronous active-low reset
//   bus   : pixel_pack_sender_if.master (pixel in, epack out, frame_done)
// pixel_ready is the only combinational output and depends on epack_ready
// alone; every other output comes straight from a register.
module pixel_pack_sender #(
   parameter int unsigned PIXELS_PER_FRAME = 3392
) (
   input  logic                clk,
   input  logic                rstn,
   pixel_pack_sender_if.master bus
);
   typedef enum logic {
      PACK_LOW  = 1'b0,
      PACK_HIGH = 1'b1
   } pack_state_t;

   localparam logic [15:0] LAST_PIX = 16'(PIXELS_PER_FRAME - 32'd1);

   pack_state_t state_r;
   logic [15:0] lo_r;
   logic [15:0] pixel_count_r;
   logic        sof_pending_r;
   logic [32:0] epack_r;
   logic        epack_valid_r;
   logic        eof_r;
   logic        frame_done_r;

   logic last_pix_s;
   logic out_free_s;
   logic pixel_ready_s;
   logic pixel_xfer_s;
   logic word_load_s;
   logic word_drain_s;

   // Handshake decode: when a pixel can be taken and whether it completes a word
   always_comb begin
      last_pix_s   = (pixel_count_r == LAST_PIX);
      // The single-entry output buffer can take a new word if empty or draining now
      out_free_s   = !epack_valid_r || bus.epack_ready;
      if ((state_r == PACK_LOW) && !last_pix_s) begin
         pixel_ready_s = 1'b1;
      end else begin
         pixel_ready_s = out_free_s;
      end
      pixel_xfer_s = bus.pixel_valid && pixel_ready_s;
      if ((state_r == PACK_HIGH) || last_pix_s) begin
         word_load_s = pixel_xfer_s;
      end else begin
         word_load_s = 1'b0;
      end
      word_drain_s = epack_valid_r && bus.epack_ready;
   end

   // Pack FSM, frame counters and the registered output word
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r       <= PACK_LOW;
         lo_r          <= 16'h0000;
         pixel_count_r <= 16'd0;
         sof_pending_r <= 1'b1;
         epack_r       <= 33'h0_0000_0000;
         epack_valid_r <= 1'b0;
         eof_r         <= 1'b0;
         frame_done_r  <= 1'b0;
      end else begin
         frame_done_r <= word_drain_s && eof_r;

         // A load wins over a drain in the same cycle so the link sees no bubble
         if (word_load_s) begin
            if (state_r == PACK_HIGH) begin
               epack_r <= {sof_pending_r, bus.pixel_in, lo_r};
            end else begin
               epack_r <= {sof_pending_r, 16'h0000, bus.pixel_in};
            end
            epack_valid_r <= 1'b1;
            eof_r         <= last_pix_s;
         end else if (word_drain_s) begin
            epack_valid_r <= 1'b0;
         end else begin
            epack_valid_r <= epack_valid_r;
         end

         if (pixel_xfer_s) begin
            // Frame wrap re-arms SOF even when the wrapping pixel also loads a word
            if (last_pix_s) begin
               pixel_count_r <= 16'd0;
               sof_pending_r <= 1'b1;
            end else begin
               pixel_count_r <= pixel_count_r + 16'd1;
               if (word_load_s) begin
                  sof_pending_r <= 1'b0;
               end else begin
                  sof_pending_r <= sof_pending_r;
               end
            end

            case (state_r)
               PACK_LOW: begin
                  if (!last_pix_s) begin
                     lo_r    <= bus.pixel_in;
                     state_r <= PACK_HIGH;
                  end else begin
                     state_r <= PACK_LOW;
                  end
               end
               PACK_HIGH: state_r <= PACK_LOW;
               default:   state_r <= PACK_LOW;
            endcase
         end
      end
   end

   assign bus.pixel_ready = pixel_ready_s;
   assign bus.epack       = epack_r;
   assign bus.epack_valid = epack_valid_r;
   assign bus.frame_done  = frame_done_r;

endmodule

// File: tb/tb_pixel_pack_sender.sv
// Bench for pixel_pack_sender: three instances (4, 3 and 3392 pixels per
// frame) share one clock; 'sel' routes the handshake to the one under test.
// Expected words come from a small frame-position model fed at every pixel
// transfer and are compared when the collector side accepts a word.
module tb_pixel_pack_sender;
   typedef struct {
      logic [32:0] word;
      logic        eof;
   } exp_t;

   logic        clk;
   logic        rstn;
   logic [1:0]  sel;
   logic [15:0] drv_pix;
   logic        drv_valid;
   logic        drv_ready;

   logic        obs_ready [3];
   logic [32:0] obs_epack [3];
   logic        obs_valid [3];
   logic        obs_fd    [3];

   logic        m_pr;
   logic        m_ev;
   logic        m_fd;
   logic [32:0] m_ep;

   logic [15:0] src_q [$];
   exp_t        exp_q [$];
   logic [32:0] got_q [$];

   int          cur_ppf;
   int          midx;
   logic [15:0] mlo;
   logic        exp_fd;
   int          fd_count;
   int          sof_count;
   int          words_seen;
   int          n_chk;
   int          n_bad;
   int          acc;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned PPF = (g == 0) ? 32'd4 : ((g == 1) ? 32'd3 : 32'd3392);
      pixel_pack_sender_if bus ();
      assign bus.pixel_in    = drv_pix;
      assign bus.pixel_valid = drv_valid && (sel == 2'(g));
      assign bus.epack_ready = drv_ready && (sel == 2'(g));
      assign obs_ready[g]    = bus.pixel_ready;
      assign obs_epack[g]    = bus.epack;
      assign obs_valid[g]    = bus.epack_valid;
      assign obs_fd[g]       = bus.frame_done;
      pixel_pack_sender #(.PIXELS_PER_FRAME(PPF)) dut (
         .clk  (clk),
         .rstn (rstn),
         .bus  (bus)
      );
   end

   assign m_pr = obs_ready[sel];
   assign m_ev = obs_valid[sel];
   assign m_ep = obs_epack[sel];
   assign m_fd = obs_fd[sel];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [32:0] act, input logic [32:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference: word content depends only on the pixel's position in the frame
   task automatic model_pixel(input logic [15:0] p);
      exp_t e;
      if ((midx % 2) == 1) begin
         e.word = {(midx == 1), p, mlo};
         e.eof  = (midx == cur_ppf - 1);
         exp_q.push_back(e);
      end else if (midx == cur_ppf - 1) begin
         e.word = {1'b0, 16'h0000, p};
         e.eof  = 1'b1;
         exp_q.push_back(e);
      end else begin
         mlo = p;
      end
      midx = (midx == cur_ppf - 1) ? 0 : midx + 1;
   endtask

   function automatic logic [32:0] got_word(input int i);
      return (got_q.size() > i) ? got_q[i] : 33'h1_FFFF_FFFF;
   endfunction

   task automatic clear_model();
      src_q.delete();
      exp_q.delete();
      got_q.delete();
      midx       = 0;
      mlo        = 16'h0000;
      exp_fd     = 1'b0;
      fd_count   = 0;
      sof_count  = 0;
      words_seen = 0;
   endtask

   task automatic do_reset();
      drv_valid = 1'b0;
      drv_ready = 1'b0;
      rstn      = 1'b0;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   // Drive until every queued pixel is taken and every expected word seen
   task automatic run_traffic(input bit rnd, input int budget, output int accept_cycles);
      int cyc;
      cyc = 0;
      accept_cycles = -1;
      while ((src_q.size() > 0 || exp_q.size() > 0 || m_ev) && cyc < budget) begin
         drv_valid = (src_q.size() > 0) && (!rnd || ($urandom_range(1, 0) == 1));
         drv_pix   = (src_q.size() > 0) ? src_q[0] : 16'h0000;
         drv_ready = !rnd || ($urandom_range(1, 0) == 1);
         @(posedge clk);
         #1;
         cyc++;
         if (src_q.size() == 0 && accept_cycles < 0) accept_cycles = cyc;
      end
      check_value("drain_budget", 33'(src_q.size() + exp_q.size()), 33'd0);
      drv_valid = 1'b0;
      drv_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Collector-side monitor: compares words and frame_done against the model
   initial begin
      exp_t e;
      logic next_fd;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            exp_fd = 1'b0;
         end else begin
            next_fd = 1'b0;
            check_value("frame_done", 33'(m_fd), 33'(exp_fd));
            if (m_fd) fd_count++;
            if (m_ev && drv_ready) begin
               got_q.push_back(m_ep);
               words_seen++;
               if (m_ep[32]) sof_count++;
               if (exp_q.size() == 0) begin
                  check_value("extra_word", 33'(exp_q.size()), 33'd1);
               end else begin
                  e = exp_q.pop_front();
                  check_value("word", m_ep, e.word);
                  next_fd = e.eof;
               end
            end
            if (drv_valid && m_pr && src_q.size() > 0) model_pixel(src_q.pop_front());
            exp_fd = next_fd;
         end
      end
   end

   initial begin
      n_chk   = 0;
      n_bad   = 0;
      sel     = 2'd0;
      drv_pix = 16'h0000;
      cur_ppf = 4;
      do_reset();

      // Reset state
      check_value("rst_epack", m_ep, 33'h0);
      check_value("rst_valid", 33'(m_ev), 33'd0);
      check_value("rst_fd", 33'(m_fd), 33'd0);
      check_value("rst_pixel_ready", 33'(m_pr), 33'd1);

      // Even frame of 4, collector always ready
      src_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      run_traffic(1'b0, 50, acc);
      check_value("f4_word0", got_word(0), 33'h1_2222_1111);
      check_value("f4_word1", got_word(1), 33'h0_4444_3333);
      check_value("f4_frame_done", 33'(fd_count), 33'd1);
      check_value("f4_throughput", 33'(acc), 33'd4);

      // Odd frame of 3 twice: padded tail, SOF returns on the next frame
      sel = 2'd1;
      cur_ppf = 3;
      do_reset();
      src_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 16'hFFFF};
      run_traffic(1'b0, 50, acc);
      check_value("f3_word0", got_word(0), 33'h1_BBBB_AAAA);
      check_value("f3_word1", got_word(1), 33'h0_0000_CCCC);
      check_value("f3_word2", got_word(2), 33'h1_EEEE_DDDD);
      check_value("f3_word3", got_word(3), 33'h0_0000_FFFF);
      check_value("f3_frame_done", 33'(fd_count), 33'd2);

      // Stall with a word pending, then simultaneous drain and refill
      sel = 2'd0;
      cur_ppf = 4;
      do_reset();
      src_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      drv_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         drv_valid = (src_q.size() > 0);
         drv_pix   = (src_q.size() > 0) ? src_q[0] : 16'h0000;
         @(posedge clk);
         #1;
         if (i >= 2) check_value("stall_hold", m_ep, 33'h1_2222_1111);
      end
      check_value("stall_taken", 33'(src_q.size()), 33'd1);
      check_value("stall_pixel_ready", 33'(m_pr), 33'd0);
      check_value("stall_valid", 33'(m_ev), 33'd1);
      drv_ready = 1'b1;
      drv_valid = 1'b1;
      drv_pix   = src_q[0];
      @(posedge clk);
      #1;
      check_value("refill_valid", 33'(m_ev), 33'd1);
      check_value("refill_word", m_ep, 33'h0_4444_3333);
      run_traffic(1'b0, 50, acc);
      check_value("stall_words", 33'(words_seen), 33'd2);
      check_value("stall_frame_done", 33'(fd_count), 33'd1);

      // Two back-to-back full frames with random gaps on both sides
      sel = 2'd2;
      cur_ppf = 3392;
      do_reset();
      for (int i = 0; i < 2 * 3392; i++) src_q.push_back(16'($urandom));
      run_traffic(1'b1, 60000, acc);
      check_value("full_words", 33'(words_seen), 33'd3392);
      check_value("full_sof", 33'(sof_count), 33'd2);
      check_value("full_frame_done", 33'(fd_count), 33'd2);

      // Asynchronous reset mid-frame, then a fresh frame start
      do_reset();
      src_q = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
      run_traffic(1'b0, 50, acc);
      check_value("pre_rst_word", got_word(1), 33'h0_0404_0303);
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check_value("arst_epack", m_ep, 33'h0);
      check_value("arst_valid", 33'(m_ev), 33'd0);
      check_value("arst_fd", 33'(m_fd), 33'd0);
      check_value("arst_pixel_ready", 33'(m_pr), 33'd1);
      clear_model();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      src_q = '{16'h0A0A, 16'h0B0B};
      run_traffic(1'b0, 50, acc);
      check_value("fresh_word", got_word(0), 33'h1_0B0B_0A0A);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
